// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial packed-BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  // 9's complement of one BCD digit; anything that is not a decimal digit maps to 0
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    logic [3:0] r;
    case (d)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: r = BCD_NINE - d;
      default:                      r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with decimal (+6) correction, purely combinational.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             cin,
  output logic [BCD_W-1:0] s,
  output logic             cout
);

  logic [BCD_W:0] raw;

  // Binary sum first, then push sums above nine back into the decimal range
  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
    if (raw > {1'b0, BCD_NINE}) begin
      s    = raw[BCD_W-1:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = raw[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, sign + magnitude result.
// Subtraction uses 10's-complement addition; a negative raw result is
// re-complemented in a second serial pass (FIX) to give |A-B|.
// Optional build macro BCD_DIGIT_CHECK_EN: flag non-decimal operand digits on err.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry,
  output logic                  neg,
  output logic                  err
);

  localparam int             W    = BCD_W * DIGITS;
  localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            mode_q;
  logic            c_q;
  logic [IW-1:0]   idx;
  logic            last;
  logic            enter_done;
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [3:0]      r_dig;
  logic [3:0]      add_x;
  logic [3:0]      add_y;
  logic [3:0]      dsum;
  logic            dcout;

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_in;
  logic err_lat;
`endif

  // Pick out the current digit of each latched operand and of the result
  always_comb begin
    a_dig = a_q[idx*BCD_W +: BCD_W];
    b_dig = b_q[idx*BCD_W +: BCD_W];
    r_dig = result[idx*BCD_W +: BCD_W];
    last  = (idx == LAST);
  end

  // One adder serves both passes: CALC adds A to B (or 9's-comp B), FIX re-complements the result
  always_comb begin
    add_x = a_dig;
    add_y = mode_q ? nines_comp(b_dig) : b_dig;
    if (state == FIX) begin
      add_x = nines_comp(r_dig);
      add_y = 4'd0;
    end
  end

  bcd_digit_adder u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (c_q),
    .s    (dsum),
    .cout (dcout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CALC;
      end
      CALC: begin
        if (last) state_nxt = (mode_q && !dcout) ? FIX : DONE;
      end
      FIX: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    enter_done = (state != DONE) && (state_nxt == DONE);
  end

`ifdef BCD_DIGIT_CHECK_EN
  // Any nibble above nine on either operand marks the request as invalid
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*BCD_W +: BCD_W] > BCD_NINE || b[i*BCD_W +: BCD_W] > BCD_NINE) bad_in = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Operand latch, serial digit datapath and held result flags
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      c_q    <= 1'b0;
      idx    <= '0;
      result <= '0;
      carry  <= 1'b0;
      neg    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_lat <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            c_q    <= mode;
            idx    <= '0;
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_lat <= bad_in;
            err     <= 1'b0;
`endif
          end
        end
        CALC, FIX: begin
          result[idx*BCD_W +: BCD_W] <= dsum;
          c_q <= dcout;
          idx <= idx + 1'b1;
          if (last) begin
            idx <= '0;
            if (state == CALC) begin
              if (!mode_q) begin
                carry <= dcout;
              end else if (!dcout) begin
                neg <= 1'b1;
                c_q <= 1'b1;
              end
            end
          end
`ifdef BCD_DIGIT_CHECK_EN
          if (enter_done && err_lat) begin
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS=4): directed table,
// hand-written control sequences and random operations against a decimal model.
module tb_bcd_addsub_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         neg;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         m;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] res;
    logic         c;
    logic         n;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .carry  (carry),
    .neg    (neg),
    .err    (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] randBcd();
    logic [W-1:0] r;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Decimal reference: plain integer arithmetic on the operand values
  task automatic refModel(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] res, output logic c, output logic n, output int lat);
    int ai, bi, lim;
    ai  = bcd2int(av);
    bi  = bcd2int(bv);
    lim = 10 ** DIGITS;
    c = 1'b0; n = 1'b0; lat = DIGITS + 1;
    if (!m) begin
      res = int2bcd((ai + bi) % lim);
      c   = (ai + bi) >= lim;
    end else if (ai >= bi) begin
      res = int2bcd(ai - bi);
    end else begin
      res = int2bcd(bi - ai);
      n   = 1'b1;
      lat = 2 * DIGITS + 1;
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, wait (bounded) for done
  task automatic applyStimulus(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                               output int lat, output int ready_bad);
    int guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    mode = m; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    mode  = ~m;
    lat = 0;
    ready_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready !== 1'b0) ready_bad++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int lat_got, rbad;
    applyStimulus(v.m, v.av, v.bv, lat_got, rbad);
    checkOutput({tag, " latency"}, lat_got, v.lat);
    checkOutput({tag, " ready while busy"}, rbad, 0);
    checkOutput({tag, " result"}, result, v.res);
    checkOutput({tag, " carry"}, carry, v.c);
    checkOutput({tag, " neg"}, neg, v.n);
    checkOutput({tag, " err"}, err, 1'b0);
    @(negedge clk);
    checkOutput({tag, " done width"}, done, 1'b0);
    checkOutput({tag, " ready after"}, ready, 1'b1);
    checkOutput({tag, " result held"}, result, v.res);
  endtask

  initial begin
    int dones, first_n, lat_got, rbad;
    logic [W-1:0] seen_res;
    vec_t rv;

    nrst = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;

    vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 5};
    vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 5};
    vecs[2] = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 5};
    vecs[3] = '{1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 9};
    vecs[4] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5};
    vecs[5] = '{1'b1, 16'h0001, 16'h9999, 16'h9998, 1'b0, 1'b1, 9};
    vecs[6] = '{1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 5};
    vecs[7] = '{1'b1, 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5};

    repeat (3) @(negedge clk);
    checkOutput("reset ready", ready, 1'b1);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset result", result, 16'h0000);
    checkOutput("reset carry", carry, 1'b0);
    checkOutput("reset neg", neg, 1'b0);
    checkOutput("reset err", err, 1'b0);
    nrst = 1'b1;

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) runVector($sformatf("vec%0d", i), vecs[i]);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    mode = 1'b0; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0; first_n = 0; seen_res = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 2) begin
        start = 1'b1; mode = 1'b1; a = 16'h9999; b = 16'h9999;
      end
      if (n == 3) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first_n == 0) begin
          first_n  = n;
          seen_res = result;
        end
      end
    end
    checkOutput("busy start done count", dones, 1);
    checkOutput("busy start latency", first_n, 5);
    checkOutput("busy start result", seen_res, 16'h6912);

    $display("[TB] reset mid-calculation");
    @(negedge clk);
    mode = 1'b0; a = 16'h4321; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (n == 3) nrst = 1'b0;
      if (n == 4) begin
        checkOutput("abort ready", ready, 1'b1);
        checkOutput("abort result", result, 16'h0000);
        checkOutput("abort done", done, 1'b0);
        nrst = 1'b1;
      end
    end
    checkOutput("abort no done", dones, 0);
    rv = '{1'b0, 16'h0042, 16'h0958, 16'h1000, 1'b0, 1'b0, 5};
    runVector("after abort", rv);

    $display("[TB] invalid digit on A");
    applyStimulus(1'b0, 16'h12A4, 16'h0001, lat_got, rbad);
    checkOutput("bad digit latency", lat_got, 5);
`ifdef BCD_DIGIT_CHECK_EN
    checkOutput("bad digit err", err, 1'b1);
    checkOutput("bad digit result", result, 16'h0000);
    checkOutput("bad digit carry", carry, 1'b0);
`else
    checkOutput("bad digit err", err, 1'b0);
`endif

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      rv.m  = 1'($urandom_range(1, 0));
      rv.av = randBcd();
      rv.bv = randBcd();
      refModel(rv.m, rv.av, rv.bv, rv.res, rv.c, rv.n, rv.lat);
      runVector($sformatf("rand%0d", i), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
